// File: rtl/slot_game_ctrl.sv
// Slot game core: credit accounting, N decimal reels, ordered stops, payout.
// Inputs are edge-detected through two register stages before use.
module slot_game_ctrl #(
    parameter int NUM_REELS  = 3,
    parameter int CREDIT_W   = 7,
    parameter int MAX_CREDIT = 99,
    parameter int PAY_ALL    = 10,
    parameter int PAY_PAIR   = 5,
    parameter int SPIN_DIV   = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   C_IN,
    input  logic                   GAME_START,
    input  logic                   STOP,
    output logic [4*NUM_REELS-1:0] REELS,
    output logic [NUM_REELS-1:0]   REEL_RUN,
    output logic [CREDIT_W-1:0]    CREDIT,
    output logic [1:0]             STATE,
    output logic [CREDIT_W-1:0]    PAYOUT,
    output logic                   WIN_PULSE
);

    localparam int IDX_W = (NUM_REELS > 1) ? $clog2(NUM_REELS) : 1;
    localparam int PS_W  = (SPIN_DIV > 1) ? $clog2(SPIN_DIV) : 1;
    localparam int SUM_W = CREDIT_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CRED = 2'd1,
        SPIN = 2'd2,
        EVAL = 2'd3
    } state_t;

    state_t               state;
    logic [2:0]           smp;
    logic [2:0]           prv;
    logic [2:0]           ev;
    logic [PS_W-1:0]      presc;
    logic                 tick;
    logic [IDX_W-1:0]     idx;
    logic                 stop_go;
    logic [NUM_REELS-1:0] stop_hit;
    logic                 all_eq;
    logic                 any_eq;
    logic [CREDIT_W-1:0]  pay;
    logic [SUM_W-1:0]     coin_sum;
    logic [CREDIT_W-1:0]  coin_credit;
    logic [CREDIT_W-1:0]  start_credit;
    logic [CREDIT_W-1:0]  eval_credit;

    function automatic logic [CREDIT_W-1:0] sat(input logic [SUM_W-1:0] v);
        if (v > SUM_W'(MAX_CREDIT))
            return CREDIT_W'(MAX_CREDIT);
        return v[CREDIT_W-1:0];
    endfunction

    function automatic logic [3:0] step_dn(input logic [3:0] d);
        return (d == 4'd0) ? 4'd9 : d - 4'd1;
    endfunction

    function automatic logic [3:0] step_up(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // ev bits: 0 = coin, 1 = start, 2 = stop
    assign ev    = smp & ~prv;
    assign tick  = (presc == PS_W'(SPIN_DIV - 1));
    assign STATE = state;

    assign stop_go = (state == SPIN) && ev[2];

    always_comb begin
        stop_hit = '0;
        for (int i = 0; i < NUM_REELS; i++)
            stop_hit[i] = stop_go && (idx == IDX_W'(i));
    end

    always_comb begin
        all_eq = 1'b1;
        any_eq = 1'b0;
        for (int i = 1; i < NUM_REELS; i++)
            if (REELS[4*i +: 4] != REELS[3:0])
                all_eq = 1'b0;
        for (int i = 0; i < NUM_REELS; i++)
            for (int j = i + 1; j < NUM_REELS; j++)
                if (REELS[4*i +: 4] == REELS[4*j +: 4])
                    any_eq = 1'b1;
        if (all_eq)
            pay = CREDIT_W'(PAY_ALL);
        else if (any_eq)
            pay = CREDIT_W'(PAY_PAIR);
        else
            pay = '0;
    end

    always_comb begin
        coin_sum     = {2'b00, CREDIT} + SUM_W'(ev[0]);
        coin_credit  = sat(coin_sum);
        // start only fires with credit >= 1, so the decrement cannot wrap
        start_credit = sat(coin_sum - SUM_W'(1));
        eval_credit  = sat(coin_sum + {2'b00, pay});
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            smp       <= '0;
            prv       <= '0;
            presc     <= '0;
            idx       <= '0;
            REELS     <= '0;
            REEL_RUN  <= '0;
            CREDIT    <= '0;
            PAYOUT    <= '0;
            WIN_PULSE <= 1'b0;
        end else begin
            smp       <= {STOP, GAME_START, C_IN};
            prv       <= smp;
            presc     <= tick ? '0 : presc + PS_W'(1);
            WIN_PULSE <= 1'b0;

            for (int i = 0; i < NUM_REELS; i++)
                if (tick && REEL_RUN[i] && !stop_hit[i])
                    REELS[4*i +: 4] <= (i % 2 == 0)
                        ? step_dn(REELS[4*i +: 4])
                        : step_up(REELS[4*i +: 4]);

            if (ev[0])
                CREDIT <= coin_credit;

            unique case (state)
                IDLE: begin
                    if (ev[0])
                        state <= CRED;
                end
                CRED: begin
                    if (ev[1] && CREDIT != '0) begin
                        CREDIT   <= start_credit;
                        REEL_RUN <= '1;
                        idx      <= '0;
                        state    <= SPIN;
                    end
                end
                SPIN: begin
                    if (stop_go) begin
                        REEL_RUN <= REEL_RUN & ~stop_hit;
                        idx      <= idx + IDX_W'(1);
                        if (idx == IDX_W'(NUM_REELS - 1))
                            state <= EVAL;
                    end
                end
                EVAL: begin
                    PAYOUT    <= pay;
                    CREDIT    <= eval_credit;
                    WIN_PULSE <= (pay != '0);
                    state     <= (eval_credit != '0) ? CRED : IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Directed bench for slot_game_ctrl with default parameters.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_slot_game_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        C_IN = 1'b0;
    logic        GAME_START = 1'b0;
    logic        STOP = 1'b0;
    logic [11:0] REELS;
    logic [2:0]  REEL_RUN;
    logic [6:0]  CREDIT;
    logic [1:0]  STATE;
    logic [6:0]  PAYOUT;
    logic        WIN_PULSE;

    int checks = 0;
    int failures = 0;

    slot_game_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .C_IN       (C_IN),
        .GAME_START (GAME_START),
        .STOP       (STOP),
        .REELS      (REELS),
        .REEL_RUN   (REEL_RUN),
        .CREDIT     (CREDIT),
        .STATE      (STATE),
        .PAYOUT     (PAYOUT),
        .WIN_PULSE  (WIN_PULSE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] dn(input logic [3:0] d);
        return (d == 4'd0) ? 4'd9 : d - 4'd1;
    endfunction

    function automatic logic [3:0] up(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    task automatic coin();
        C_IN = 1'b1;
        @(negedge CLK);
        C_IN = 1'b0;
        @(negedge CLK);
    endtask

    task automatic start();
        GAME_START = 1'b1;
        @(negedge CLK);
        GAME_START = 1'b0;
        @(negedge CLK);
    endtask

    task automatic stop_pulse();
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        @(negedge CLK);
    endtask

    // Press STOP right after reel r steps onto tgt, leaving a full
    // tick period for the two-cycle edge-detect latency.
    task automatic stop_at(input int r, input logic [3:0] tgt);
        logic [3:0] prev;
        logic [3:0] cur;
        bit hit;
        int n;
        hit = 0;
        n = 0;
        prev = REELS[4*r +: 4];
        while (!hit && n < 100) begin
            @(negedge CLK);
            n++;
            cur = REELS[4*r +: 4];
            if (cur == tgt && prev != tgt)
                hit = 1;
            prev = cur;
        end
        chk($sformatf("reach_reel%0d", r), 32'(hit), 1);
        stop_pulse();
        chk($sformatf("stopped_reel%0d", r), 32'(REELS[4*r +: 4]), 32'(tgt));
    endtask

    task automatic play(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input int pay,
                        input int cred, input int st);
        stop_at(0, a);
        chk("run_after_stop0", 32'(REEL_RUN), 3'b110);
        stop_at(1, b);
        chk("run_after_stop1", 32'(REEL_RUN), 3'b100);
        stop_at(2, c);
        chk("eval_state", 32'(STATE), 3);
        chk("eval_run", 32'(REEL_RUN), 0);
        chk("eval_nowin", 32'(WIN_PULSE), 0);
        @(negedge CLK);
        chk("payout", 32'(PAYOUT), 32'(pay));
        chk("credit_after_eval", 32'(CREDIT), 32'(cred));
        chk("win_pulse", 32'(WIN_PULSE), 32'(pay != 0));
        chk("state_after_eval", 32'(STATE), 32'(st));
        @(negedge CLK);
        chk("win_pulse_end", 32'(WIN_PULSE), 0);
        chk("reels_held", 32'(REELS), 32'({c, b, a}));
    endtask

    initial begin
        logic [3:0] e0;
        logic [3:0] e1;
        logic [3:0] e2;
        logic [3:0] p0;
        int last;
        int steps;

        repeat (2) @(negedge CLK);
        chk("rst_reels", 32'(REELS), 0);
        chk("rst_run", 32'(REEL_RUN), 0);
        chk("rst_credit", 32'(CREDIT), 0);
        chk("rst_state", 32'(STATE), 0);
        chk("rst_payout", 32'(PAYOUT), 0);
        chk("rst_win", 32'(WIN_PULSE), 0);
        RST = 1'b0;
        @(negedge CLK);

        start();
        chk("idle_ignores_start", 32'(STATE), 0);

        repeat (3) coin();
        chk("credit3", 32'(CREDIT), 3);
        chk("state_credit", 32'(STATE), 1);
        start();
        chk("credit_after_start", 32'(CREDIT), 2);
        chk("state_spin", 32'(STATE), 2);
        chk("run_all", 32'(REEL_RUN), 3'b111);

        // Reels start at zero: reel0/2 count down, reel1 counts up.
        e0 = 4'd0;
        e1 = 4'd0;
        e2 = 4'd0;
        p0 = REELS[3:0];
        last = -1;
        steps = 0;
        for (int c = 0; c < 44; c++) begin
            @(negedge CLK);
            if (REELS[3:0] != p0) begin
                e0 = dn(e0);
                e1 = up(e1);
                e2 = dn(e2);
                steps++;
                chk("step_values", 32'(REELS), 32'({e2, e1, e0}));
                if (last >= 0)
                    chk("step_period", 32'(c - last), 4);
                last = c;
                p0 = REELS[3:0];
            end
        end
        chk("step_count", 32'(steps), 11);

        STOP = 1'b1;
        repeat (10) @(negedge CLK);
        STOP = 1'b0;
        repeat (2) @(negedge CLK);
        chk("hold_stops_one", 32'(REEL_RUN), 3'b110);
        chk("hold_state", 32'(STATE), 2);
        start();
        chk("spin_ignores_start", 32'(STATE), 2);
        stop_pulse();
        chk("second_stop", 32'(REEL_RUN), 3'b100);
        stop_pulse();
        chk("third_stop_run", 32'(REEL_RUN), 3'b000);
        chk("third_stop_eval", 32'(STATE), 3);
        @(negedge CLK);
        chk("eval_one_cycle", 32'(STATE), 1);

        repeat (120) coin();
        chk("saturate", 32'(CREDIT), 99);
        start();
        chk("sat_start", 32'(CREDIT), 98);
        repeat (3) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_reels", 32'(REELS), 0);
        chk("async_rst_run", 32'(REEL_RUN), 0);
        chk("async_rst_credit", 32'(CREDIT), 0);
        chk("async_rst_state", 32'(STATE), 0);
        chk("async_rst_payout", 32'(PAYOUT), 0);
        chk("async_rst_win", 32'(WIN_PULSE), 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        coin();
        chk("first_coin", 32'(CREDIT), 1);
        chk("first_coin_state", 32'(STATE), 1);

        repeat (4) coin();
        chk("credit5", 32'(CREDIT), 5);
        C_IN = 1'b1;
        GAME_START = 1'b1;
        @(negedge CLK);
        C_IN = 1'b0;
        GAME_START = 1'b0;
        @(negedge CLK);
        chk("coin_start_credit", 32'(CREDIT), 5);
        chk("coin_start_state", 32'(STATE), 2);
        chk("coin_start_run", 32'(REEL_RUN), 3'b111);

        play(4'd4, 4'd4, 4'd4, 10, 15, 1);
        start();
        chk("credit14", 32'(CREDIT), 14);
        play(4'd4, 4'd7, 4'd4, 5, 19, 1);
        start();
        chk("credit18", 32'(CREDIT), 18);
        play(4'd1, 4'd2, 4'd3, 0, 18, 1);

        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        coin();
        start();
        chk("credit0_spin", 32'(CREDIT), 0);
        chk("credit0_state", 32'(STATE), 2);
        play(4'd1, 4'd2, 4'd3, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/slot_game_ctrl.md
# slot_game_ctrl

Parametrised sequential core of the coin-operated slot game: credit accounting, N spinning decimal reels, ordered stop sequencing and payout evaluation. It replaces the fixed three-reel, three-stop-button controller with a generic reel count, a single STOP button, saturating credit and configurable payouts. The display path (BCD conversion, 7-segment scan, text LCD select) sits downstream and consumes `REELS`, `CREDIT` and `STATE`.

## Interface
- `NUM_REELS`, 3: number of reels; must be ≥ 2.
- `CREDIT_W`, 7: credit and payout width.
- `MAX_CREDIT`, 99: saturation ceiling for credit; must be < 2^CREDIT_W.
- `PAY_ALL`, 10: payout when all reels are equal.
- `PAY_PAIR`, 5: payout when at least one pair is equal but not all.
- `SPIN_DIV`, 4: CLK cycles per reel step; must be ≥ 1.

- `CLK`, in, 1: clock.
- `RST`, in, 1: reset; asynchronous, active-high.
- `C_IN`, in, 1: coin input, level, pre-synchronised.
- `GAME_START`, in, 1: start button, level, pre-synchronised.
- `STOP`, in, 1: stop button, level, pre-synchronised.
- `REELS`, out, 4*NUM_REELS: reel digits 0–9; reel i occupies [4i+3:4i].
- `REEL_RUN`, out, NUM_REELS: bit i is high while reel i spins.
- `CREDIT`, out, CREDIT_W: current credit.
- `STATE`, out, 2: 0 = IDLE, 1 = CREDIT, 2 = SPIN, 3 = EVAL.
- `PAYOUT`, out, CREDIT_W: payout of the last evaluated game.
- `WIN_PULSE`, out, 1: one-cycle pulse when a nonzero payout is credited.

## Operation
- **Edge detection:** each of `C_IN`, `GAME_START` and `STOP` is registered. An event is input = 1 with the previous registered value = 0. Holding a level generates exactly one event.
- **Coin event:** in any state, `CREDIT` = min(`CREDIT` + 1, `MAX_CREDIT`).
- **IDLE:** a coin event moves to CREDIT. `GAME_START` is ignored.
- **CREDIT:** a start event with `CREDIT` ≥ 1 does the following:
  - `CREDIT` decrements.
  - All `REEL_RUN` bits set.
  - The stop index is cleared to 0.
  - The state moves to SPIN.
  - If a coin and a start arrive in the same cycle, the net credit change is 0 (+1 −1, saturation applied after the decrement).
- **SPIN:**
  - A stop event clears `REEL_RUN[idx]` and increments idx.
  - When the last reel (idx = NUM_REELS−1) stops, the state moves to EVAL.
  - `GAME_START` is ignored.
- **Reel stepping:** a free-running prescaler counts 0..SPIN_DIV−1 and produces a tick at terminal count. On a tick, each running reel steps.
  - Even-indexed reels count down: 0 → 9 wraps.
  - Odd-indexed reels count up: 9 → 0 wraps.
  - A reel stopped in the same cycle as a tick does not step.
- **EVAL:** lasts exactly one cycle. Payout is `PAY_ALL` if all reels are equal, else `PAY_PAIR` if any two reels are equal, else 0.
  - `PAYOUT` is loaded with the payout value.
  - `CREDIT` = min(`CREDIT` + payout + coin, `MAX_CREDIT`).
  - The next state is CREDIT if the resulting credit is > 0, else IDLE.
- **Reset values:** `REELS` = 0, `REEL_RUN` = 0, `CREDIT` = 0, `STATE` = IDLE, `PAYOUT` = 0, `WIN_PULSE` = 0, prescaler = 0, stop index = 0, edge registers = 0.
- **Reset mid-game:** all of the above values are restored immediately. Credit in flight is lost.

## Timing
- All outputs are registered.
- An input rising at edge k is sampled at edge k. Its effect is visible after edge k+1 (one cycle of edge-detect latency).
- Start event to `STATE` = SPIN and `REEL_RUN` all-ones: 1 cycle after the event is detected.
- Last stop event to `STATE` = EVAL: 1 cycle. EVAL to `CREDIT`/`PAYOUT` update plus `WIN_PULSE`: 1 cycle.
- `WIN_PULSE` is high for exactly the one cycle following EVAL, and only when payout > 0.
- Reel step period while running is exactly `SPIN_DIV` CLK cycles.

## Test plan
- **Coins and start:** reset, then 3 coin pulses → `CREDIT` = 3, `STATE` = CREDIT. Then a start → `CREDIT` = 2, `STATE` = SPIN, `REEL_RUN` = 3'b111.
- **Saturation:** 120 coin pulses (defaults) → `CREDIT` = 99. Coin and start in the same cycle at credit 5 → `CREDIT` stays 5 and the state goes to SPIN.
- **Ordered stops:** in SPIN, three stop pulses → `REEL_RUN` goes 110 → 100 → 000. `STATE` reaches EVAL after the 3rd stop and lasts one cycle. Holding `STOP` high for 10 cycles stops only one reel.
- **Payouts:** force reel timing so the digits end as (4,4,4) → `PAYOUT` = 10, `CREDIT` += 10, `WIN_PULSE` for one cycle. (4,7,4) → `PAYOUT` = 5. (1,2,3) → `PAYOUT` = 0, no `WIN_PULSE`, and `STATE` returns to IDLE if credit is 0.
- **Stepping and wrap:** with `SPIN_DIV` = 4, reel0 steps 0 → 9 → 8 every 4 cycles and reel1 steps 0 → 1 → 2. Run 40 cycles and check that both wrap correctly.
- **Reset mid-game:** assert `RST` asynchronously mid-SPIN → all outputs return to reset values within the same cycle, with no clock edge needed. After release, the first coin gives `CREDIT` = 1.
